demux_scan_ctrl: RTL and testbench

//  Upstream sequencer for the 1-to-8 demux: drives its select (a,b,c) and enable (e).

---
 rtl/demux_scan_ctrl_if.sv | 27 ++
 rtl/demux_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_demux_scan_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_scan_ctrl_if.sv
// Control/status bundle between a scan master and demux_scan_ctrl,
// including the demux select/enable lines it drives.
interface demux_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               abort;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               cont;
  logic               a;
  logic               b;
  logic               c;
  logic               e;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, mask, dwell, cont,
    input  a, b, c, e, busy, done
  );

  modport slave (
    input  start, abort, mask, dwell, cont,
    output a, b, c, e, busy, done
  );
endinterface

// File: rtl/demux_scan_ctrl.sv
// Scan sequencer for a 1-to-8 demux: walks a channel mask in ascending order,
// holding the enable for a programmable dwell, and only moves select while e is low.
module demux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  demux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    ON   = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [3:0]         first_s;
  logic [3:0]         next_s;

  // Returns {found, index} of the lowest set bit of m at or above floor_idx.
  function automatic logic [3:0] pick_lowest(input logic [7:0] m, input logic [3:0] floor_idx);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= floor_idx)) begin
        r = {1'b1, 3'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign first_s = pick_lowest(mask_q, 4'd0);
  assign next_s  = pick_lowest(mask_q, {1'b0, sel_q} + 4'd1);

  // Next-state and output decode for the scan sequence.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        e_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          if (bus.mask != 8'h00) begin
            mask_d  = bus.mask;
            dwell_d = (bus.dwell == DWELL_ZERO) ? DWELL_ONE : bus.dwell;
            cont_d  = bus.cont;
            busy_d  = 1'b1;
            state_d = SEEK;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEEK: begin
        if (bus.abort) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sel_d   = first_s[2:0];
          cnt_d   = dwell_q;
          e_d     = 1'b1;
          state_d = ON;
        end
      end
      ON: begin
        if (bus.abort) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q <= DWELL_ONE) begin
          e_d     = 1'b0;
          state_d = GAP;
        end else begin
          cnt_d   = cnt_q - DWELL_ONE;
        end
      end
      GAP: begin
        // Select may only move here, where e is already low.
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (next_s[3]) begin
          sel_d   = next_s[2:0];
          cnt_d   = dwell_q;
          e_d     = 1'b1;
          state_d = ON;
        end else if (cont_q) begin
          sel_d   = first_s[2:0];
          cnt_d   = dwell_q;
          e_d     = 1'b1;
          state_d = ON;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        e_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 8'h00;
      dwell_q <= DWELL_ZERO;
      cont_q  <= 1'b0;
      sel_q   <= 3'd0;
      cnt_q   <= DWELL_ZERO;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a    = sel_q[2];
  assign bus.b    = sel_q[1];
  assign bus.c    = sel_q[0];
  assign bus.e    = e_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: a timeline model of each scan is queued
// per cycle, and a negedge monitor compares {sel,e,busy,done} against it.
module tb_demux_scan_ctrl;
  localparam int DW = 8;

  typedef struct packed {
    int         cyc;
    logic [5:0] v;     // {sel[2:0], e, busy, done}
  } ent_t;

  logic clk;
  logic rst_n;
  int   cyc_cnt;
  int   n_cmp;
  int   n_fail;
  ent_t exp_q[$];
  logic [2:0] m_sel;

  demux_scan_ctrl_if #(.DWELL_W(DW)) bus();

  demux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [5:0] mk(input logic [2:0] s, input logic e, input logic b, input logic d);
    return {s, e, b, d};
  endfunction

  // Monitor: compares every queued expectation at the cycle it belongs to.
  always @(negedge clk) begin
    ent_t   x;
    logic [5:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
      x = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missed_check cyc=%0d required=%b", x.cyc, x.v);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
      x   = exp_q.pop_front();
      act = {bus.a, bus.b, bus.c, bus.e, bus.busy, bus.done};
      n_cmp++;
      if (act !== x.v) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d {sel,e,busy,done} actual=%b required=%b", cyc_cnt, act, x.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.start = 1'($urandom);
    bus.mask  = 8'($urandom);
    bus.dwell = 8'($urandom);
    bus.cont  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rst_n     = 1'b1;
      rand_inputs();
      bus.start = 1'b0;
      bus.abort = 1'($urandom);
      exp_q.push_back('{cyc: cyc_cnt + 1, v: mk(m_sel, 1'b0, 1'b0, 1'b0)});
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_n     = 1'b0;
      rand_inputs();
      bus.abort = 1'($urandom);
      exp_q.push_back('{cyc: cyc_cnt + 1, v: mk(3'd0, 1'b0, 1'b0, 1'b0)});
      tick();
    end
    m_sel = 3'd0;
    rst_n = 1'b1;
  endtask

  // cut>=0: interrupt the scan at that trace index by abort or reset.
  task automatic run_scan(input logic [7:0] m, input logic [7:0] dw, input logic ct,
                          input int cut, input bit by_reset);
    logic [5:0] t[$];
    int d;
    int base;
    logic [2:0] last;
    d    = (dw == 8'd0) ? 1 : int'(dw);
    base = cyc_cnt + 1;
    if (m == 8'h00) begin
      t.push_back(mk(m_sel, 1'b0, 1'b0, 1'b1));
    end else begin
      t.push_back(mk(m_sel, 1'b0, 1'b1, 1'b0));
      do begin
        for (int ch = 0; ch < 8; ch++) begin
          if (m[ch]) begin
            for (int k = 0; k < d; k++) t.push_back(mk(3'(ch), 1'b1, 1'b1, 1'b0));
            t.push_back(mk(3'(ch), 1'b0, 1'b1, 1'b0));
            last = 3'(ch);
          end
        end
      end while (ct && t.size() <= cut);
      if (!ct) t.push_back(mk(last, 1'b0, 1'b0, 1'b1));
    end
    if (cut >= 0 && cut < t.size() && (by_reset || cut >= 1)) begin
      logic [5:0] cv;
      cv = by_reset ? mk(3'd0, 1'b0, 1'b0, 1'b0) : mk(t[cut-1][5:3], 1'b0, 1'b0, 1'b0);
      while (t.size() > cut) void'(t.pop_back());
      t.push_back(cv);
    end else begin
      cut = -1;
    end
    m_sel = t[t.size()-1][5:3];
    for (int i = 0; i < t.size(); i++) exp_q.push_back('{cyc: base + i, v: t[i]});
    for (int i = 0; i < t.size(); i++) begin
      rst_n     = 1'b1;
      bus.abort = 1'b0;
      if (i == 0) begin
        bus.start = 1'b1;
        bus.mask  = m;
        bus.dwell = dw;
        bus.cont  = ct;
      end else begin
        rand_inputs();
      end
      if (i == cut) begin
        if (by_reset) rst_n = 1'b0;
        else bus.abort = 1'b1;
      end
      tick();
    end
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    m_sel     = 3'd0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mask  = 8'h00;
    bus.dwell = 8'd0;
    bus.cont  = 1'b0;

    do_reset(2);
    idle(2);
    run_scan(8'h05, 8'd3, 1'b0, -1, 1'b0);
    idle(2);
    run_scan(8'h00, 8'd4, 1'b0, -1, 1'b0);
    idle(2);
    run_scan(8'h80, 8'd0, 1'b1, 9, 1'b0);
    idle(2);
    run_scan(8'h81, 8'd2, 1'b1, 14, 1'b0);
    idle(1);
    run_scan(8'h24, 8'd4, 1'b0, 3, 1'b1);
    idle(2);
    run_scan(8'hff, 8'd1, 1'b0, -1, 1'b0);
    run_scan(8'h42, 8'd2, 1'b0, 6, 1'b0);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] m;
      logic [7:0] dw;
      logic       ct;
      int         cut;
      bit         rs;
      m   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dw  = 8'($urandom_range(0, 5));
      ct  = 1'($urandom);
      rs  = ($urandom_range(0, 3) == 0);
      cut = (ct || $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      if (ct && cut < 1) cut = 1;
      run_scan(m, dw, ct, cut, rs);
      idle($urandom_range(0, 2));
    end

    idle(3);
    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL leftover_checks actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
